// File: rtl/matrix_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_pkg                                                               |
// | Shared constants and index-width helper for the matrix serializer.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package matrix_pkg;

    localparam int MATRIX_SLOTS = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_index_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_index_counter                                                     |
// | Row-major row/column walker; wraps to [0][0] after [N-1][M-1].           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter int N = 3,
    parameter int M = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                advance,
    output logic [idx_w(N)-1:0] row,
    output logic [idx_w(M)-1:0] col,
    output logic                last
);

    localparam int RW = idx_w(N);
    localparam int CW = idx_w(M);
    localparam logic [RW-1:0] c_ROW_MAX = RW'(N - 1);
    localparam logic [CW-1:0] c_COL_MAX = CW'(M - 1);

    logic [RW-1:0] r_row_q, w_row_d;
    logic [CW-1:0] r_col_q, w_col_d;

    always_comb begin
        w_row_d = r_row_q;
        w_col_d = r_col_q;
        if (advance) begin
            if (r_col_q == c_COL_MAX) begin
                w_col_d = '0;
                w_row_d = (r_row_q == c_ROW_MAX) ? '0 : r_row_q + RW'(1);
            end else begin
                w_col_d = r_col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_q <= '0;
            r_col_q <= '0;
        end else begin
            r_row_q <= w_row_d;
            r_col_q <= w_col_d;
        end
    end

    assign row  = r_row_q;
    assign col  = r_col_q;
    assign last = (r_row_q == c_ROW_MAX) && (r_col_q == c_COL_MAX);

endmodule
`default_nettype wire

// File: rtl/matrix_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_serializer                                                        |
// | Ping-pong capture of an N x M matrix, streamed row-major over            |
// | valid/ready. Optional index ports: MATRIX_SERIALIZER_INDEX_EN.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module matrix_serializer
    import matrix_pkg::*;
#(
    parameter int BITS = 16,
    parameter int N    = 3,
    parameter int M    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [BITS-1:0]     in_data [N][M],
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITS-1:0]     out_data,
    output logic                out_last,
    output logic                overflow
`ifdef MATRIX_SERIALIZER_INDEX_EN
    ,
    output logic [idx_w(N)-1:0] out_row,
    output logic [idx_w(M)-1:0] out_col
`endif
);

    localparam int RW = idx_w(N);
    localparam int CW = idx_w(M);
    localparam logic [1:0] c_FULL = 2'(MATRIX_SLOTS);

    logic [BITS-1:0] r_buf_q [MATRIX_SLOTS][N][M];
    logic [BITS-1:0] w_buf_d [MATRIX_SLOTS][N][M];
    logic            r_wr_sel_q, w_wr_sel_d;
    logic            r_rd_sel_q, w_rd_sel_d;
    logic [1:0]      r_count_q, w_count_d;
    logic            r_overflow_q, w_overflow_d;

    logic [RW-1:0]   w_row;
    logic [CW-1:0]   w_col;
    logic            w_idx_last;
    logic            w_handshake;
    logic            w_pop;
    logic            w_capture;

    assign out_valid   = (r_count_q != 2'd0);
    assign w_handshake = out_valid && out_ready;
    assign w_pop       = w_handshake && w_idx_last;
    // A slot being vacated this cycle may be refilled in the same cycle.
    assign w_capture   = in_valid && ((r_count_q < c_FULL) || w_pop);
    assign in_ready    = (r_count_q < c_FULL) || w_pop;

    matrix_index_counter #(
        .N (N),
        .M (M)
    ) u_index (
        .clk     (clk),
        .rst     (rst),
        .advance (w_handshake),
        .row     (w_row),
        .col     (w_col),
        .last    (w_idx_last)
    );

    always_comb begin
        w_buf_d      = r_buf_q;
        w_wr_sel_d   = r_wr_sel_q;
        w_rd_sel_d   = r_rd_sel_q;
        w_count_d    = r_count_q;
        w_overflow_d = r_overflow_q;
        if (w_capture) begin
            w_buf_d[r_wr_sel_q] = in_data;
            w_wr_sel_d          = ~r_wr_sel_q;
        end
        if (in_valid && !w_capture) begin
            w_overflow_d = 1'b1;
        end
        if (w_pop) begin
            w_rd_sel_d = ~r_rd_sel_q;
        end
        if (w_capture && !w_pop) begin
            w_count_d = r_count_q + 2'd1;
        end else if (w_pop && !w_capture) begin
            w_count_d = r_count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_sel_q   <= 1'b0;
            r_rd_sel_q   <= 1'b0;
            r_count_q    <= 2'd0;
            r_overflow_q <= 1'b0;
        end else begin
            r_wr_sel_q   <= w_wr_sel_d;
            r_rd_sel_q   <= w_rd_sel_d;
            r_count_q    <= w_count_d;
            r_overflow_q <= w_overflow_d;
        end
    end

    // Slot storage carries no reset; only the pointers and count are cleared.
    always_ff @(posedge clk) begin
        r_buf_q <= w_buf_d;
    end

    assign out_data = out_valid ? r_buf_q[r_rd_sel_q][w_row][w_col] : '0;
    assign out_last = out_valid && w_idx_last;
    assign overflow = r_overflow_q;

`ifdef MATRIX_SERIALIZER_INDEX_EN
    assign out_row = out_valid ? w_row : '0;
    assign out_col = out_valid ? w_col : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_matrix_serializer                                                     |
// | Directed self-checking bench for matrix_serializer (N=3, M=2, BITS=16).  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_matrix_serializer;

    localparam int BITS = 16;
    localparam int N    = 3;
    localparam int M    = 2;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [BITS-1:0] in_data [N][M];
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_data;
    logic            out_last;
    logic            overflow;
`ifdef MATRIX_SERIALIZER_INDEX_EN
    logic [1:0]      out_row;
    logic [0:0]      out_col;
`endif

    int errors = 0;
    int checks = 0;

    matrix_serializer #(
        .BITS (BITS),
        .N    (N),
        .M    (M)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow)
`ifdef MATRIX_SERIALIZER_INDEX_EN
        ,
        .out_row   (out_row),
        .out_col   (out_col)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Matrix element [r][c] = base + r*M + c.
    task automatic load(input int base);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < M; c++)
                in_data[r][c] = BITS'(base + r * M + c);
    endtask

    task automatic expect_elem(input string tag, input int v, input bit last);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_data"},  32'(out_data), v);
        chk({tag, "_last"},  32'(out_last), 32'(last));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_data"},  32'(out_data), 0);
        chk({tag, "_last"},  32'(out_last), 0);
    endtask

    initial begin
        int v;
        int idx;
        int k;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        load(0);
        repeat (2) @(negedge clk);
        expect_idle("reset");
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        rst = 1'b0;

        // Single matrix, free-flowing consumer
        @(negedge clk); load(1); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            expect_elem("t1", i, i == 6);
            @(negedge clk);
        end
        expect_idle("t1_end");
        chk("t1_overflow", 32'(overflow), 0);

        // Back-to-back strobes, no bubble between matrices
        @(negedge clk); load(1); in_valid = 1'b1;
        @(negedge clk); load(11);
        expect_elem("t2", 1, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            v = (i < 6) ? i + 1 : i + 5;
            expect_elem("t2", v, (v == 6) || (v == 16));
            @(negedge clk);
        end
        expect_idle("t2_end");
        chk("t2_overflow", 32'(overflow), 0);

        // Third strobe while both slots full is dropped
        out_ready = 1'b0;
        @(negedge clk); load(1); in_valid = 1'b1;
        @(negedge clk); load(11);
        @(negedge clk); load(21);
        chk("t3_in_ready_full", 32'(in_ready), 0);
        chk("t3_overflow_pre", 32'(overflow), 0);
        @(negedge clk); in_valid = 1'b0;
        chk("t3_overflow", 32'(overflow), 1);
        expect_elem("t3_hold", 1, 1'b0);
        @(negedge clk);
        expect_elem("t3_hold2", 1, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            v = (i < 6) ? i + 1 : i + 5;
            expect_elem("t3", v, (v == 6) || (v == 16));
            @(negedge clk);
        end
        expect_idle("t3_end");
        chk("t3_overflow_sticky", 32'(overflow), 1);
        rst = 1'b1; #1; rst = 1'b0;
        chk("t3_overflow_cleared", 32'(overflow), 0);

        // Capture coincident with pop while full
        out_ready = 1'b0;
        @(negedge clk); load(1); in_valid = 1'b1;
        @(negedge clk); load(11);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            expect_elem("t4", i, 1'b0);
            @(negedge clk);
        end
        expect_elem("t4", 6, 1'b1);
        load(21); in_valid = 1'b1;
        chk("t4_in_ready_pop", 32'(in_ready), 1);
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            v = (i < 6) ? i + 11 : i + 15;
            expect_elem("t4", v, (v == 16) || (v == 26));
            @(negedge clk);
        end
        expect_idle("t4_end");
        chk("t4_overflow", 32'(overflow), 0);

        // Toggling ready: elements held while not accepted
        @(negedge clk); load(1); in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b0;
        idx = 0;
        k = 0;
        while (idx < 6 && k < 40) begin
            expect_elem("t5", idx + 1, idx == 5);
`ifdef MATRIX_SERIALIZER_INDEX_EN
            chk("t5_row", 32'(out_row), idx / 2);
            chk("t5_col", 32'(out_col), idx % 2);
`endif
            out_ready = (k % 2 == 0);
            @(negedge clk);
            if (out_ready) idx++;
            k++;
        end
        chk("t5_accepted", 32'(idx), 6);
        expect_idle("t5_end");
`ifdef MATRIX_SERIALIZER_INDEX_EN
        chk("t5_row_idle", 32'(out_row), 0);
        chk("t5_col_idle", 32'(out_col), 0);
`endif

        // Asynchronous reset mid-matrix, then restart
        out_ready = 1'b1;
        @(negedge clk); load(1); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        expect_elem("t6", 1, 1'b0);
        @(negedge clk);
        expect_elem("t6", 2, 1'b0);
        @(negedge clk);
        expect_elem("t6", 3, 1'b0);
        #2 rst = 1'b1;
        #1 expect_idle("t6_rst");
        chk("t6_rst_in_ready", 32'(in_ready), 1);
        @(negedge clk); rst = 1'b0; load(31); in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        for (int i = 31; i <= 36; i++) begin
            expect_elem("t6_restart", i, i == 36);
            @(negedge clk);
        end
        expect_idle("t6_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_serializer.md
# matrix_serializer

Downstream stage of the matrix adder: captures each parallel `BITS`-wide N×M result matrix on a single-cycle `in_valid` and streams its elements one per cycle in row-major order over a valid/ready handshake. The producer has no backpressure, so the block holds two matrix slots (ping-pong) to absorb a new result while the previous one drains. A sticky overflow flag reports any matrix dropped because both slots were full. It feeds narrow consumers: output FIFOs, UART/AXI-Stream bridges and scoreboards.

## Interface
- `BITS`, 16, element width (opaque bit pattern, any precision)
- `N`, 3, rows
- `M`, 2, columns
- `clk`  input  1  clock; all state changes on the rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `in_valid`  input  1  one-cycle strobe; `in_data` is valid this cycle
- `in_data`  input  `[BITS-1:0]` `[N][M]`  result matrix from the adder
- `in_ready`  output  1  at least one slot free, or a slot is freeing this cycle (informational only)
- `out_valid`  output  1  `out_data` holds a valid element
- `out_ready`  input  1  consumer accepts the element
- `out_data`  output  `BITS`  current element
- `out_last`  output  1  current element is `[N-1][M-1]` of its matrix
- `overflow`  output  1  sticky; a matrix was dropped
- `out_row`  output  `$clog2(N)` (min 1)  row index of `out_data`; present only with the configuration macro
- `out_col`  output  `$clog2(M)` (min 1)  column index of `out_data`; present only with the configuration macro

## Operation
- State:
  - two slots `buf[2][N][M]`
  - `wr_sel`, `rd_sel` (1 bit each)
  - `count` (0..2)
  - row counter `r` (0..N-1) and column counter `c` (0..M-1)
- Handshake: fires when `out_valid && out_ready`.
- Pop: the handshake on the element where `out_last` is high.
- Capture:
  - Happens when `in_valid` is high and either `count < 2` or a pop occurs in the same cycle.
  - On capture, `buf[wr_sel]` is loaded from `in_data` and `wr_sel` toggles.
- Drop:
  - Happens when `in_valid` is high, `count == 2` and there is no pop.
  - Buffers, pointers and `count` are unchanged; `overflow` is set to 1.
- Read path:
  - `out_valid = (count != 0)`.
  - `out_data = buf[rd_sel][r][c]` while `out_valid` is high, otherwise 0.
  - `out_last = out_valid && r == N-1 && c == M-1`.
- Counter advance on each handshake:
  - `c` increments.
  - At `c == M-1`, `c` wraps to 0 and `r` increments.
  - At the last element, `r` and `c` wrap to 0 and `rd_sel` toggles.
- `count` update:
  - +1 on capture without pop
  - −1 on pop without capture
  - unchanged when both or neither occur
- `out_valid` high with `out_ready` low: `out_data`, `out_last` and the indices stay stable.
- N=1 or M=1: the corresponding counter stays at 0.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_last` 0, `overflow` 0, `in_ready` 1, `count` 0, `r`/`c` 0, `wr_sel`/`rd_sel` 0. Slot contents are not reset.
- `rst` asserted mid-stream: the current matrix is abandoned immediately and asynchronously; outputs take reset values.
- Latency: capture at edge T, first element (`out_valid` 1) visible after edge T.
- Throughput: N·M cycles per matrix with `out_ready` held high. Back-to-back pops across matrices have no bubble.
- `in_ready = (count < 2) || pop` (combinational).
- `overflow` clears only on `rst`.

## Configuration
- `MATRIX_SERIALIZER_INDEX_EN` defined: `out_row`/`out_col` exist and equal the current `r`/`c`. They are 0 when `out_valid` is 0.
- Not defined: the ports are absent; `r`/`c` remain internal.

## Structure
- Package `matrix_pkg`:
  - function `idx_w(n)` returning `max(1, $clog2(n))`
  - constant `MATRIX_SLOTS = 2`
- Sub-module `matrix_index_counter`:
  - parameters `N`, `M`
  - ports: `clk`, `rst`, `advance`, `row`, `col`, `last`
  - provides the row/column wrap logic; instantiated once

## Test plan
- Single matrix, N=3, M=2, `in_data` = 1..6 row-major, `out_ready` high → `out_data` 1,2,3,4,5,6 on the six cycles after capture; `out_last` only with 6; then `out_valid` 0.
- Two strobes on consecutive cycles (1..6, then 11..16), `out_ready` high → twelve continuous elements 1..6, 11..16; `overflow` stays 0.
- Three strobes with `out_ready` low → the first two matrices are kept and the third is dropped; `overflow` = 1 after the third capture edge; releasing `out_ready` yields only the first two matrices.
- `count == 2` and `in_valid` coincident with the pop of element 6 → the new matrix is captured; `overflow` stays 0; the stream continues without a gap.
- `out_ready` toggled 1,0,1,0 → each element held stable while not accepted; order unchanged. With `MATRIX_SERIALIZER_INDEX_EN`, (`out_row`, `out_col`) step (0,0),(0,1),(1,0)…
- `rst` pulsed asynchronously while the 3rd element is presented → `out_valid` 0 immediately; the next strobe restarts at element [0][0].
